// File: rtl/button_debouncer_if.sv
// rtl/button_debouncer_if.sv - button debouncer signal bundle (raw buttons in, debounced level/pulses out)
interface button_debouncer_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] btn;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] release_;
  logic [N_CH-1:0] toggle;

  modport master (output btn, input level, press, release_, toggle);
  modport slave  (input btn, output level, press, release_, toggle);
endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - per-channel 2-flop sync + stability-counter debouncer; toggle flops built only with DEBOUNCE_TOGGLE_EN
module button_debouncer #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input logic            clk,
  input logic            rst,
  button_debouncer_if.slave bus
);

  // Counter value at which a differing sample is accepted as the new level.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  logic [N_CH-1:0]  sync1;
  logic [N_CH-1:0]  sync2;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [N_CH-1:0]  levelQ;
  logic [N_CH-1:0]  pressQ;
  logic [N_CH-1:0]  releaseQ;
  logic [N_CH-1:0]  differ;
  logic [N_CH-1:0]  accept;

  // Two-stage synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.btn;
      sync2 <= sync1;
    end
  end

  // A channel flips its level once the synchronised input has disagreed for STABLE_CYCLES samples.
  always_comb begin
    differ = '0;
    accept = '0;
    for (int i = 0; i < N_CH; i++) begin
      differ[i] = sync2[i] ^ levelQ[i];
      accept[i] = differ[i] && (cnt[i] == LAST_CNT);
    end
  end

  // Stability counters: cleared on agreement or acceptance, so they never pass LAST_CNT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!differ[i] || accept[i]) cnt[i] <= '0;
        else                         cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Debounced level and its edge pulses are registered together on the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      levelQ   <= '0;
      pressQ   <= '0;
      releaseQ <= '0;
    end else begin
      levelQ   <= levelQ ^ accept;
      pressQ   <= accept & sync2;
      releaseQ <= accept & ~sync2;
    end
  end

`ifdef DEBOUNCE_TOGGLE_EN
  logic [N_CH-1:0] toggleQ;

  // Toggle state flips on the edge following each press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) toggleQ <= '0;
    else     toggleQ <= toggleQ ^ pressQ;
  end

  assign bus.toggle = toggleQ;
`else
  assign bus.toggle = '0;
`endif

  assign bus.level    = levelQ;
  assign bus.press    = pressQ;
  assign bus.release_ = releaseQ;

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - table-driven bench for button_debouncer (N_CH=4, STABLE_CYCLES=3)
module tb_button_debouncer;

`ifdef DEBOUNCE_TOGGLE_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] btn;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] tog;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  button_debouncer_if #(.N_CH(4)) bus ();

  button_debouncer #(.N_CH(4), .STABLE_CYCLES(3), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] eL, input logic [3:0] eP,
                          input logic [3:0] eR, input logic [3:0] eT);
    check({tag, " level"},   bus.level,    eL);
    check({tag, " press"},   bus.press,    eP);
    check({tag, " release"}, bus.release_, eR);
    check({tag, " toggle"},  bus.toggle,   TOG_EN ? eT : 4'b0000);
  endtask

  // Drive btn, let one rising edge pass, sample on the following falling edge.
  task automatic step(input string tag, input logic [3:0] b, input logic [3:0] eL,
                      input logic [3:0] eP, input logic [3:0] eR, input logic [3:0] eT);
    bus.btn = b;
    @(posedge clk);
    @(negedge clk);
    checkAll(tag, eL, eP, eR, eT);
  endtask

  function automatic void add(input logic [3:0] b, input logic [3:0] l, input logic [3:0] p,
                              input logic [3:0] r, input logic [3:0] t);
    vec_t v;
    v.btn = b; v.level = l; v.press = p; v.rel = r; v.tog = t;
    vecs.push_back(v);
  endfunction

  initial begin
    // idle after reset
    for (int i = 0; i < 3; i++) add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // clean press on ch0: level at 4th edge after the input edge
    for (int i = 0; i < 4; i++) add(4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
    add(4'h1, 4'h1, 4'h0, 4'h0, 4'h1);
    add(4'h1, 4'h1, 4'h0, 4'h0, 4'h1);
    // clean release on ch0
    for (int i = 0; i < 4; i++) add(4'h0, 4'h1, 4'h0, 4'h0, 4'h1);
    add(4'h0, 4'h0, 4'h0, 4'h1, 4'h1);
    add(4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
    // ch2 high for only 2 sync samples: filtered out
    add(4'h4, 4'h0, 4'h0, 4'h0, 4'h1);
    add(4'h4, 4'h0, 4'h0, 4'h0, 4'h1);
    for (int i = 0; i < 4; i++) add(4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
    // ch1 bounces 1,0,1,0 then settles at 1
    add(4'h2, 4'h0, 4'h0, 4'h0, 4'h1);
    add(4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
    add(4'h2, 4'h0, 4'h0, 4'h0, 4'h1);
    add(4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
    for (int i = 0; i < 4; i++) add(4'h2, 4'h0, 4'h0, 4'h0, 4'h1);
    add(4'h2, 4'h2, 4'h2, 4'h0, 4'h1);
    add(4'h2, 4'h2, 4'h0, 4'h0, 4'h3);
    for (int i = 0; i < 4; i++) add(4'h0, 4'h2, 4'h0, 4'h0, 4'h3);
    add(4'h0, 4'h0, 4'h0, 4'h2, 4'h3);
    add(4'h0, 4'h0, 4'h0, 4'h0, 4'h3);
    // all channels rise together, fall 20 cycles later
    for (int i = 0; i < 4; i++) add(4'hF, 4'h0, 4'h0, 4'h0, 4'h3);
    add(4'hF, 4'hF, 4'hF, 4'h0, 4'h3);
    for (int i = 5; i < 20; i++) add(4'hF, 4'hF, 4'h0, 4'h0, 4'hC);
    for (int i = 0; i < 4; i++) add(4'h0, 4'hF, 4'h0, 4'h0, 4'hC);
    add(4'h0, 4'h0, 4'h0, 4'hF, 4'hC);
    for (int i = 0; i < 3; i++) add(4'h0, 4'h0, 4'h0, 4'h0, 4'hC);

    bus.btn = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAll("reset_state", 4'h0, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].btn, vecs[i].level, vecs[i].press,
           vecs[i].rel, vecs[i].tog);

    // ch0 pressed, then ch3 starts filtering and reset hits with its count at 1
    for (int i = 0; i < 4; i++) step("rst_pre", 4'h1, 4'h0, 4'h0, 4'h0, 4'hC);
    step("rst_pre_press", 4'h1, 4'h1, 4'h1, 4'h0, 4'hC);
    step("rst_pre_tog", 4'h1, 4'h1, 4'h0, 4'h0, 4'hD);
    for (int i = 0; i < 3; i++) step("rst_pre_ch3", 4'h9, 4'h1, 4'h0, 4'h0, 4'hD);
    rst = 1'b1;
    #1;
    checkAll("rst_async", 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 2; i++) step("rst_held", 4'h9, 4'h0, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step($sformatf("post_rst%0d", i + 1), 4'h9, 4'h0, 4'h0, 4'h0, 4'h0);
    step("post_rst5_press", 4'h9, 4'h9, 4'h9, 4'h0, 4'h0);
    step("post_rst6_tog", 4'h9, 4'h9, 4'h0, 4'h0, 4'h9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, legal range 1..32.
REQ-002 Parameter STABLE_CYCLES, default 3: consecutive synchronised samples required to accept a level change, legal range 1..255.
REQ-003 Parameter CNT_W, default 8: stability counter width; SHALL satisfy 2^CNT_W > STABLE_CYCLES.
REQ-004 clk  input  1  sampling clock (500 Hz in the lab top level).
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 btn  input  N_CH  raw active-high button levels, asynchronous to clk, may bounce.
REQ-007 level  output  N_CH  debounced stable level per channel.
REQ-008 press  output  N_CH  one-cycle pulse on each accepted 0->1 transition.
REQ-009 release  output  N_CH  one-cycle pulse on each accepted 1->0 transition.
REQ-010 toggle  output  N_CH  per-channel state flipped on each press (see Configuration).

Function
REQ-011 Each channel SHALL pass btn[i] through a 2-flop synchroniser (sync1, sync2) before any other use.
REQ-012 Each channel SHALL hold a CNT_W-bit counter cnt[i] and a stable bit level[i]; channels SHALL share no state.
REQ-013 On each clk edge where sync2[i] == level[i]: cnt[i] SHALL be cleared to 0.
REQ-014 On each clk edge where sync2[i] != level[i] and cnt[i] < STABLE_CYCLES-1: cnt[i] SHALL increment by 1.
REQ-015 On each clk edge where sync2[i] != level[i] and cnt[i] == STABLE_CYCLES-1: level[i] SHALL take sync2[i] and cnt[i] SHALL clear to 0.
REQ-016 Latency: a clean btn change set up before edge k SHALL appear on level at edge k+1+STABLE_CYCLES (2 synchroniser edges plus STABLE_CYCLES filter edges).
REQ-017 A btn excursion held for fewer than STABLE_CYCLES consecutive sync2 samples SHALL NOT change level, and SHALL NOT produce press or release pulses.
REQ-018 press[i] SHALL be registered high for exactly the one cycle in which level[i] goes 0->1; release[i] SHALL do likewise for 1->0.
REQ-019 press[i] and release[i] SHALL never be high simultaneously; after any pulse, the next pulse on that channel SHALL come at least STABLE_CYCLES cycles later.
REQ-020 cnt[i] SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-021 Simultaneous transitions on several channels SHALL each be processed independently in the same cycle.
REQ-022 All outputs SHALL be driven directly from flops, with no combinational path from btn.

Reset
REQ-023 While rst is high: sync1, sync2, cnt, level, press, release and toggle SHALL all be 0, asynchronously.
REQ-024 Reset asserted mid-filter SHALL discard the partial count; a button still held after rst deasserts SHALL produce a fresh press at edge 2+STABLE_CYCLES after deassertion.
REQ-025 Reset deassertion SHALL be synchronous to clk at the top level; the block SHALL NOT create pulses on the deassertion edge itself.

Configuration
REQ-026 Macro DEBOUNCE_TOGGLE_EN defined: toggle[i] SHALL invert on the clock edge after each press[i] pulse and is cleared only by rst.
REQ-027 Macro DEBOUNCE_TOGGLE_EN undefined: the toggle port SHALL remain present, SHALL be tied to 0, and SHALL instantiate no toggle flops.

Verification (N_CH=4, STABLE_CYCLES=3, DEBOUNCE_TOGGLE_EN defined unless stated)
REQ-028 Step btn=4'b0001 before edge 10 and hold it -> level[0] rises at edge 14, press[0] is high only in cycle 14, and toggle[0]=1 from edge 15.
REQ-029 btn[1] bounces 1,0,1,0 on alternate cycles, then holds 1 -> no pulses during the bounce; a single press[1] occurs 5 edges after the final settle.
REQ-030 btn[2] is high for exactly 2 sync2 samples -> level[2] stays 0, no press, and cnt returns to 0.
REQ-031 All 4 buttons rise in the same cycle, then fall 20 cycles later -> 4 simultaneous press pulses, then 4 simultaneous release pulses, 20 cycles apart.
REQ-032 Assert rst while btn[3] is held with cnt=1, then release rst and keep btn[3]=1 -> all outputs 0 during reset; press[3] at edge 5 after deassertion.
REQ-033 DEBOUNCE_TOGGLE_EN undefined, 3 presses on channel 0 -> toggle stays 4'b0000 while press and level behave identically to REQ-028.
